mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage plus MEM/WB register. Takes EXE/MEM results, runs LB/LW/SB/SW on the data memory
//  over a req/ack handshake, stalls upstream while a transaction is open, then registers everything
//  write-back consumes (wb_dre, raw bus word wb_dm, reg/HILO/CP0 writes). Writeback does extension and lane swap.
// PARAMETERS
//  ADDR_W         32  data-memory byte address width
//  EXC_CODE_ADEL  4   exception code, misaligned load (MEM_ALIGN_EXC_EN only)
//  EXC_CODE_ADES  5   exception code, misaligned store (MEM_ALIGN_EXC_EN only)
// PORTS
//  clk           in   1       pipeline clock
//  rst_n         in   1       async active-low reset
//  flush_i       in   1       load bubble into MEM/WB register this edge
//  mem_op_i      in   3       MOP_NONE/LB/LW/SB/SW
//  mem_wa_i      in   5       dest register;   mem_wreg_i in 1  reg write enable
//  mem_wd_i      in   32      ALU result; effective address for memory ops
//  mem_din_i     in   32      store data (rt)
//  mem_whilo_i   in   1       HI/LO write;     mem_hilo_i in 64  HI/LO data
//  cp0_we_i/cp0_waddr_i/cp0_wdata_i  in 1/5/32  CP0 write bundle
//  dm_req_o      out  1       bus request, held until ack
//  dm_we_o       out  4       byte write enables (0 for loads)
//  dm_addr_o     out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  dm_wdata_o    out  32      lane-swapped store data
//  dm_ack_i      in   1       completes the transaction; dm_rdata_i valid same cycle
//  dm_rdata_i    in   32      raw read word
//  stall_req_o   out  1       freeze PC..EXE/MEM
//  wb_wa_o 5, wb_wreg_o 1, wb_dreg_o 32, wb_mreg_o 1, wb_dre_o 4, wb_dm_o 32,
//  wb_whilo_o 1, wb_hilo_o 64, cp0_we_o 1, cp0_waddr_o 5, cp0_wdata_o 32   out  registered WB inputs
//  exc_o 1, exc_code_o 5, badvaddr_o 32   out  registered address-error report
// BEHAVIOUR
//  - Reset/flush: every output 0, FSM IDLE. Reset mid-transaction drops dm_req_o at once; no retry.
//  - Lanes (a=addr[1:0]): byte offset 0 on [31:24]. LB/SB lane = 4'b1000>>a; LW/SW = 4'b1111.
//    SW wdata {d[7:0],d[15:8],d[23:16],d[31:24]}; SB wdata {4{d[7:0]}}, dm_we_o = lane.
//  - Non-memory op: no stall; MEM/WB loads next edge (1 cycle); wb_mreg_o=0, wb_dre_o=0.
//  - FSM IDLE: memory op present -> stall_req_o=1 (comb), latch addr/we/wdata, go BUSY.
//    BUSY: dm_req_o=1, addr/we/wdata stable. ack=0 -> stay, stall_req_o=1.
//    ack=1 -> stall_req_o=0 same cycle; MEM/WB loads with wb_dm_o=dm_rdata_i (loads) or 0
//    (stores); -> IDLE. Minimum memory-op latency 2 cycles; ack in first BUSY cycle allowed.
//  - Loads: wb_mreg_o=1, wb_dre_o=lane. Stores: wb_wreg_o=0, wb_mreg_o=0.
//  - While stall_req_o=1 the MEM/WB register holds a bubble (wreg/whilo/cp0_we=0).
//  - flush_i in BUSY: transaction runs to ack (a store still writes), result discarded; stall held until ack.
//  - Back-to-back memory ops: IDLE after ack -> next op restarts at IDLE, no dm_req_o gap
//    shorter than 1 cycle.
// CONFIGURATION
//  MEM_ALIGN_EXC_EN defined: LW/SW with a!=0 issue no request, no stall; next edge exc_o=1,
//    exc_code_o=ADEL/ADES, badvaddr_o=mem_wd_i, WB fields bubbled. exc_o pulses 1 cycle.
//  Undefined: a ignored for LW/SW (aligned access), exc_o/exc_code_o/badvaddr_o tied 0.
// STRUCTURE
//  Shared defines header: MOP_* codes (3b), lane patterns, EXC_CODE_* defaults, FSM state codes.
//  Sub-module mem_lane_gen: comb (op, addr, din) -> (dre, we, wdata); reused by testbench model.
//  Top: FSM, latch regs, MEM/WB register, optional alignment checker.
// TESTING
//  1 LW addr 0x100, ack after 3 BUSY cycles, rdata 0x44332211 -> stall 4 cycles, wb_dre_o=1111,
//    wb_dm_o=0x44332211, wb_mreg_o=1, req held constant throughout.
//  2 SB addr 0x203, din 0x000000A5 -> dm_we_o=0001, dm_wdata_o=0xA5A5A5A5, addr 0x200, wb_wreg_o=0.
//  3 LB addr 0x7FE ack immediate -> 2-cycle op, wb_dre_o=0010; then ADDU passes in 1 cycle.
//  4 flush_i during BUSY SW -> write completes on ack, MEM/WB all zero, stall drops with ack.
//  5 rst_n low in BUSY -> dm_req_o=0 and all outputs 0 asynchronously; resumes clean from IDLE.
//  6 MEM_ALIGN_EXC_EN, LW addr 0x102 -> no dm_req_o, exc_o=1, exc_code_o=4, badvaddr_o=0x102;
//    without macro -> normal LW at 0x100.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: memory-op codes, byte-lane patterns,
// address-error codes, FSM states and the request/MEM-WB payload structs.
package mem_access_stage_pkg;

  localparam logic [2:0] MOP_NONE = 3'd0;
  localparam logic [2:0] MOP_LB   = 3'd1;
  localparam logic [2:0] MOP_LW   = 3'd2;
  localparam logic [2:0] MOP_SB   = 3'd3;
  localparam logic [2:0] MOP_SW   = 3'd4;

  // Byte offset 0 lives on [31:24]; byte lanes shift right as the offset grows.
  localparam logic [3:0] LANE_B0 = 4'b1000;
  localparam logic [3:0] LANE_W  = 4'b1111;

  localparam logic [4:0] EXC_CODE_ADEL_DEF = 5'd4;
  localparam logic [4:0] EXC_CODE_ADES_DEF = 5'd5;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [3:0]  dre;
    logic        is_load;
  } dm_txn_t;

  typedef struct packed {
    logic [4:0]  wa;
    logic        wreg;
    logic [31:0] dreg;
    logic        mreg;
    logic [3:0]  dre;
    logic [31:0] dm;
    logic        whilo;
    logic [63:0] hilo;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        exc;
    logic [4:0]  exc_code;
    logic [31:0] badvaddr;
  } memwb_t;

  function automatic logic mop_is_mem(input logic [2:0] op);
    return (op == MOP_LB) || (op == MOP_LW) || (op == MOP_SB) || (op == MOP_SW);
  endfunction

  function automatic logic mop_is_load(input logic [2:0] op);
    return (op == MOP_LB) || (op == MOP_LW);
  endfunction

endpackage

// File: rtl/mem_access_stage_lane_gen.sv
// Byte-lane generator: maps (op, low address bits, store data) to read-lane
// mask, bus byte write enables and lane-swapped store data.
module mem_lane_gen
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] din_i,
  output logic [3:0]  dre_o,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o
);

  logic [3:0] blane;
  assign blane = LANE_B0 >> addr_i;

  always_comb begin
    dre_o   = '0;
    we_o    = '0;
    wdata_o = '0;
    case (op_i)
      MOP_LB: dre_o = blane;
      MOP_LW: dre_o = LANE_W;
      MOP_SB: begin
        dre_o   = blane;
        we_o    = blane;
        wdata_o = {4{din_i[7:0]}};
      end
      MOP_SW: begin
        dre_o   = LANE_W;
        we_o    = LANE_W;
        wdata_o = {din_i[7:0], din_i[15:8], din_i[23:16], din_i[31:24]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage + MEM/WB register with a two-state req/ack data-memory FSM.
// Define MEM_ALIGN_EXC_EN to trap misaligned LW/SW as address errors.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int         ADDR_W        = 32,
  parameter logic [4:0] EXC_CODE_ADEL = EXC_CODE_ADEL_DEF,
  parameter logic [4:0] EXC_CODE_ADES = EXC_CODE_ADES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [2:0]        mem_op_i,
  input  logic [4:0]        mem_wa_i,
  input  logic              mem_wreg_i,
  input  logic [31:0]       mem_wd_i,
  input  logic [31:0]       mem_din_i,
  input  logic              mem_whilo_i,
  input  logic [63:0]       mem_hilo_i,
  input  logic              cp0_we_i,
  input  logic [4:0]        cp0_waddr_i,
  input  logic [31:0]       cp0_wdata_i,
  output logic              dm_req_o,
  output logic [3:0]        dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [31:0]       dm_wdata_o,
  input  logic              dm_ack_i,
  input  logic [31:0]       dm_rdata_i,
  output logic              stall_req_o,
  output logic [4:0]        wb_wa_o,
  output logic              wb_wreg_o,
  output logic [31:0]       wb_dreg_o,
  output logic              wb_mreg_o,
  output logic [3:0]        wb_dre_o,
  output logic [31:0]       wb_dm_o,
  output logic              wb_whilo_o,
  output logic [63:0]       wb_hilo_o,
  output logic              cp0_we_o,
  output logic [4:0]        cp0_waddr_o,
  output logic [31:0]       cp0_wdata_o,
  output logic              exc_o,
  output logic [4:0]        exc_code_o,
  output logic [31:0]       badvaddr_o
);

`ifdef MEM_ALIGN_EXC_EN
  localparam bit ALIGN_EXC = 1'b1;
`else
  localparam bit ALIGN_EXC = 1'b0;
`endif

  state_e            state_q, state_d;
  dm_txn_t           txn_q, txn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              kill_q, kill_d;
  memwb_t            wb_q, wb_d;
  logic              stall, busy, misalign, ld, st;
  logic [3:0]        lg_dre, lg_we;
  logic [31:0]       lg_wdata;

  mem_lane_gen u_lane (
    .op_i    (mem_op_i),
    .addr_i  (mem_wd_i[1:0]),
    .din_i   (mem_din_i),
    .dre_o   (lg_dre),
    .we_o    (lg_we),
    .wdata_o (lg_wdata)
  );

  assign busy     = (state_q == S_BUSY);
  assign misalign = ALIGN_EXC && !busy && ((mem_op_i == MOP_LW) || (mem_op_i == MOP_SW))
                    && (mem_wd_i[1:0] != 2'b00);

  // A flushed op still launches nothing; a flush seen while BUSY only marks
  // the result for discard, the bus transaction runs to completion.
  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    addr_d  = addr_q;
    kill_d  = kill_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mop_is_mem(mem_op_i) && !misalign && !flush_i) begin
          stall   = 1'b1;
          txn_d   = '{we: lg_we, wdata: lg_wdata, dre: lg_dre, is_load: mop_is_load(mem_op_i)};
          addr_d  = {mem_wd_i[ADDR_W-1:2], 2'b00};
          kill_d  = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (dm_ack_i) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          if (flush_i) kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_d = '0;
    ld   = busy && txn_q.is_load;
    st   = busy && !txn_q.is_load;
    if (!flush_i && !stall) begin
      if (misalign) begin
        wb_d.exc      = 1'b1;
        wb_d.exc_code = (mem_op_i == MOP_LW) ? EXC_CODE_ADEL : EXC_CODE_ADES;
        wb_d.badvaddr = mem_wd_i;
      end else if (!(busy && kill_q)) begin
        wb_d.wa        = mem_wa_i;
        wb_d.wreg      = mem_wreg_i && !st;
        wb_d.dreg      = mem_wd_i;
        wb_d.mreg      = ld;
        wb_d.dre       = ld ? txn_q.dre : 4'b0000;
        wb_d.dm        = ld ? dm_rdata_i : 32'h0;
        wb_d.whilo     = mem_whilo_i;
        wb_d.hilo      = mem_hilo_i;
        wb_d.cp0_we    = cp0_we_i;
        wb_d.cp0_waddr = cp0_waddr_i;
        wb_d.cp0_wdata = cp0_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      txn_q   <= '0;
      addr_q  <= '0;
      kill_q  <= 1'b0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      addr_q  <= addr_d;
      kill_q  <= kill_d;
      wb_q    <= wb_d;
    end
  end

  // Bus fields are only driven while a request is open.
  assign dm_req_o    = busy;
  assign dm_we_o     = busy ? txn_q.we : 4'b0000;
  assign dm_addr_o   = busy ? addr_q : '0;
  assign dm_wdata_o  = busy ? txn_q.wdata : 32'h0;
  assign stall_req_o = stall && rst_n;

  assign wb_wa_o     = wb_q.wa;
  assign wb_wreg_o   = wb_q.wreg;
  assign wb_dreg_o   = wb_q.dreg;
  assign wb_mreg_o   = wb_q.mreg;
  assign wb_dre_o    = wb_q.dre;
  assign wb_dm_o     = wb_q.dm;
  assign wb_whilo_o  = wb_q.whilo;
  assign wb_hilo_o   = wb_q.hilo;
  assign cp0_we_o    = wb_q.cp0_we;
  assign cp0_waddr_o = wb_q.cp0_waddr;
  assign cp0_wdata_o = wb_q.cp0_wdata;
  assign exc_o       = wb_q.exc;
  assign exc_code_o  = wb_q.exc_code;
  assign badvaddr_o  = wb_q.badvaddr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; honours MEM_ALIGN_EXC_EN for the
// misaligned-LW case.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [2:0]  mem_op_i;
  logic [4:0]  mem_wa_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wd_i, mem_din_i;
  logic        mem_whilo_i;
  logic [63:0] mem_hilo_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic        dm_req_o;
  logic [3:0]  dm_we_o;
  logic [31:0] dm_addr_o, dm_wdata_o;
  logic        dm_ack_i;
  logic [31:0] dm_rdata_i;
  logic        stall_req_o;
  logic [4:0]  wb_wa_o;
  logic        wb_wreg_o;
  logic [31:0] wb_dreg_o;
  logic        wb_mreg_o;
  logic [3:0]  wb_dre_o;
  logic [31:0] wb_dm_o;
  logic        wb_whilo_o;
  logic [63:0] wb_hilo_o;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        exc_o;
  logic [4:0]  exc_code_o;
  logic [31:0] badvaddr_o;

  int checks = 0;
  int failures = 0;
  int stall_n;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .mem_op_i(mem_op_i),
    .mem_wa_i(mem_wa_i), .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
    .mem_din_i(mem_din_i), .mem_whilo_i(mem_whilo_i), .mem_hilo_i(mem_hilo_i),
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_wdata_o(dm_wdata_o), .dm_ack_i(dm_ack_i), .dm_rdata_i(dm_rdata_i),
    .stall_req_o(stall_req_o), .wb_wa_o(wb_wa_o), .wb_wreg_o(wb_wreg_o),
    .wb_dreg_o(wb_dreg_o), .wb_mreg_o(wb_mreg_o), .wb_dre_o(wb_dre_o),
    .wb_dm_o(wb_dm_o), .wb_whilo_o(wb_whilo_o), .wb_hilo_o(wb_hilo_o),
    .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
    .exc_o(exc_o), .exc_code_o(exc_code_o), .badvaddr_o(badvaddr_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] wa, input logic wreg,
                       input logic [31:0] wd, input logic [31:0] din);
    mem_op_i = op; mem_wa_i = wa; mem_wreg_i = wreg; mem_wd_i = wd; mem_din_i = din;
    #1;
  endtask

  task automatic chk_wb_zero(input string tag);
    chk(tag, {wb_wa_o, wb_wreg_o, wb_dreg_o, wb_mreg_o, wb_dre_o, wb_whilo_o,
              cp0_we_o, cp0_waddr_o, exc_o, exc_code_o}, 64'h0);
    chk({tag, "_dm"}, {wb_dm_o, cp0_wdata_o}, 64'h0);
    chk({tag, "_hilo"}, wb_hilo_o, 64'h0);
    chk({tag, "_bva"}, badvaddr_o, 64'h0);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; mem_op_i = MOP_NONE; mem_wa_i = '0; mem_wreg_i = 1'b0;
    mem_wd_i = '0; mem_din_i = '0; mem_whilo_i = 1'b0; mem_hilo_i = '0; cp0_we_i = 1'b0;
    cp0_waddr_i = '0; cp0_wdata_i = '0; dm_ack_i = 1'b0; dm_rdata_i = '0;
    #3;
    chk("rst_bus", {dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o[3:0], stall_req_o}, 64'h0);
    chk_wb_zero("rst_wb");
    tick();
    rst_n = 1'b1;
    tick();

    // 1: LW 0x100, three BUSY cycles without ack
    stall_n = 0;
    drive(MOP_LW, 5'd5, 1'b1, 32'h100, 32'h0);
    chk("t1_noreq_idle", dm_req_o, 1'b0);
    if (stall_req_o) stall_n++;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("t1_req_held", {dm_req_o, dm_addr_o, dm_we_o}, {1'b1, 32'h100, 4'b0000});
      chk("t1_wb_bubble", wb_wreg_o, 1'b0);
      if (stall_req_o) stall_n++;
      tick();
    end
    dm_ack_i = 1'b1; dm_rdata_i = 32'h44332211;
    #1;
    chk("t1_stall_cycles", stall_n, 4);
    chk("t1_ack_stall", {stall_req_o, dm_req_o, dm_addr_o}, {1'b0, 1'b1, 32'h100});
    tick();
    dm_ack_i = 1'b0; dm_rdata_i = '0;
    drive(MOP_NONE, 5'd0, 1'b0, 32'h0, 32'h0);
    chk("t1_wb", {wb_mreg_o, wb_dre_o, wb_wreg_o, wb_wa_o, wb_dreg_o},
        {1'b1, 4'b1111, 1'b1, 5'd5, 32'h100});
    chk("t1_wb_dm", wb_dm_o, 32'h44332211);
    chk("t1_req_drop", dm_req_o, 1'b0);

    // 2: SB 0x203
    drive(MOP_SB, 5'd6, 1'b1, 32'h203, 32'h000000A5);
    chk("t2_stall_idle", stall_req_o, 1'b1);
    tick();
    chk("t2_bus", {dm_req_o, dm_we_o, dm_addr_o}, {1'b1, 4'b0001, 32'h200});
    chk("t2_wdata", dm_wdata_o, 32'hA5A5A5A5);
    dm_ack_i = 1'b1;
    #1;
    tick();
    dm_ack_i = 1'b0;
    drive(MOP_NONE, 5'd0, 1'b0, 32'h0, 32'h0);
    chk("t2_wb", {wb_wreg_o, wb_mreg_o, wb_dre_o, wb_dm_o}, {1'b0, 1'b0, 4'b0, 32'h0});
    chk("t2_wb_dreg", wb_dreg_o, 32'h203);

    // 3: LB 0x7FE, immediate ack, then ADDU
    drive(MOP_LB, 5'd7, 1'b1, 32'h7FE, 32'h0);
    chk("t3_stall_idle", stall_req_o, 1'b1);
    tick();
    dm_ack_i = 1'b1; dm_rdata_i = 32'h12345678;
    #1;
    chk("t3_ack", {stall_req_o, dm_req_o, dm_we_o, dm_addr_o}, {1'b0, 1'b1, 4'b0, 32'h7FC});
    tick();
    dm_ack_i = 1'b0; dm_rdata_i = '0;
    chk("t3_wb", {wb_mreg_o, wb_dre_o, wb_wa_o, wb_dm_o}, {1'b1, 4'b0010, 5'd7, 32'h12345678});
    mem_whilo_i = 1'b1; mem_hilo_i = 64'h0123456789ABCDEF;
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'hCAFE0001;
    drive(MOP_NONE, 5'd9, 1'b1, 32'hDEAD, 32'h0);
    chk("t3_addu_nostall", {stall_req_o, dm_req_o}, 2'b00);
    tick();
    chk("t3_addu_wb", {wb_wa_o, wb_wreg_o, wb_dreg_o, wb_mreg_o, wb_dre_o},
        {5'd9, 1'b1, 32'hDEAD, 1'b0, 4'b0});
    chk("t3_addu_hilo", {wb_whilo_o, wb_hilo_o[62:0]}, {1'b1, 63'h0123456789ABCDEF});
    chk("t3_addu_cp0", {cp0_we_o, cp0_waddr_o, cp0_wdata_o}, {1'b1, 5'd12, 32'hCAFE0001});

    // 4: SW with flush while BUSY
    mem_whilo_i = 1'b0; mem_hilo_i = '0; cp0_we_i = 1'b0; cp0_waddr_i = '0; cp0_wdata_i = '0;
    drive(MOP_SW, 5'd3, 1'b0, 32'h300, 32'h11223344);
    tick();
    chk("t4_bus", {dm_req_o, dm_we_o, dm_addr_o}, {1'b1, 4'b1111, 32'h300});
    chk("t4_wdata", dm_wdata_o, 32'h44332211);
    flush_i = 1'b1;
    #1;
    chk("t4_flush_stall", stall_req_o, 1'b1);
    tick();
    flush_i = 1'b0;
    #1;
    chk("t4_held", {stall_req_o, dm_req_o}, 2'b11);
    dm_ack_i = 1'b1;
    #1;
    chk("t4_ack_write", {stall_req_o, dm_req_o, dm_we_o}, {1'b0, 1'b1, 4'b1111});
    tick();
    dm_ack_i = 1'b0;
    drive(MOP_NONE, 5'd0, 1'b0, 32'h0, 32'h0);
    chk_wb_zero("t4_wb_discard");

    // 5: async reset in BUSY
    drive(MOP_LW, 5'd2, 1'b1, 32'h400, 32'h0);
    tick();
    chk("t5_busy", dm_req_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_bus", {dm_req_o, dm_we_o, dm_addr_o, stall_req_o}, 64'h0);
    chk_wb_zero("t5_rst_wb");
    drive(MOP_NONE, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_idle", {dm_req_o, stall_req_o}, 2'b00);
    drive(MOP_LB, 5'd1, 1'b1, 32'h001, 32'h0);
    tick();
    dm_ack_i = 1'b1; dm_rdata_i = 32'h00AB0000;
    #1;
    tick();
    dm_ack_i = 1'b0; dm_rdata_i = '0;
    drive(MOP_NONE, 5'd0, 1'b0, 32'h0, 32'h0);
    chk("t5_resume", {wb_mreg_o, wb_dre_o, wb_dm_o}, {1'b1, 4'b0100, 32'h00AB0000});

    // 6: misaligned LW 0x102
    drive(MOP_LW, 5'd4, 1'b1, 32'h102, 32'h0);
`ifdef MEM_ALIGN_EXC_EN
    chk("t6_noreq", {dm_req_o, stall_req_o}, 2'b00);
    tick();
    chk("t6_exc", {exc_o, exc_code_o, badvaddr_o}, {1'b1, 5'd4, 32'h102});
    chk("t6_wb_bubble", {wb_wreg_o, wb_mreg_o, dm_req_o}, 3'b000);
    drive(MOP_SW, 5'd4, 1'b0, 32'h301, 32'h0);
    tick();
    chk("t6_ades", {exc_o, exc_code_o, badvaddr_o}, {1'b1, 5'd5, 32'h301});
    drive(MOP_NONE, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("t6_pulse", exc_o, 1'b0);
`else
    chk("t6_stall", stall_req_o, 1'b1);
    tick();
    chk("t6_aligned", {dm_req_o, dm_addr_o, dm_we_o}, {1'b1, 32'h100, 4'b0000});
    dm_ack_i = 1'b1; dm_rdata_i = 32'hCAFEF00D;
    #1;
    tick();
    dm_ack_i = 1'b0; dm_rdata_i = '0;
    drive(MOP_NONE, 5'd0, 1'b0, 32'h0, 32'h0);
    chk("t6_wb", {wb_dre_o, wb_mreg_o, wb_dm_o}, {4'b1111, 1'b1, 32'hCAFEF00D});
    chk("t6_noexc", {exc_o, exc_code_o, badvaddr_o}, 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
